uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 16_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge triggered.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line from the computer; idle high.
REQ-006 SHALL have port data  output  8  last received byte.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data when valid && ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  sticky flag: a byte was dropped.

Function
REQ-011 SHALL compute DIV = CLK_FREQ / BAUD with integer truncation (138 at the defaults) and HALF = DIV / 2 (69).
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_s); both flops reset to 1; all decisions use rx_s only.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with a bit-period counter and a 3-bit bit index.
REQ-014 IDLE: when rx_s == 0, go to START and load the counter with HALF-1.
REQ-015 START: at counter 0, sample rx_s; if 0, go to DATA with counter DIV-1 and bit index 0; if 1 (glitch), return to IDLE with no output activity.
REQ-016 DATA: at each counter 0, shift rx_s into the shift register LSB first and reload DIV-1; after bit index 7, go to STOP.
REQ-017 STOP: at counter 0, sample rx_s; if 1, complete the byte and go to IDLE; if 0, pulse frame_err for exactly one cycle, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s == 1, then go to IDLE; this prevents a break condition from being taken as new start bits.
REQ-019 On completion, if valid == 0 or ready == 1 in the same cycle: the next cycle, data = byte and valid = 1.
REQ-020 On completion with valid == 1 and ready == 0: keep data unchanged, drop the new byte, and set overrun = 1 the next cycle.
REQ-021 valid SHALL clear the cycle after valid && ready, unless a completion in that same cycle reloads it (REQ-019).
REQ-022 overrun SHALL stay set until the cycle after the next valid && ready handshake.
REQ-023 data SHALL be stable while valid == 1 and change only on a valid load.
REQ-024 Latency: valid rises 1 clk after the stop-bit mid-sample, about 9.5 bit periods plus 2 synchronizer clocks after the rx falling edge.
REQ-025 ready while valid == 0 SHALL have no effect.
REQ-026 The receiver SHALL tolerate at least ±2% baud mismatch at the defaults, because every bit is sampled mid-period.

Reset
REQ-027 While reset is high: state = IDLE, counters = 0, data = 8'h00, valid = 0, frame_err = 0, overrun = 0, synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err; after release, reception resumes from IDLE at the next falling edge.
REQ-029 Reset SHALL take effect asynchronously; deassertion is assumed synchronous to clk externally.

Verification
REQ-030 With ready = 1, send 0x55 then 0xA3 at 115200 baud (16 MHz clk) -> two one-cycle valid pulses with data = 0x55 then 0xA3; frame_err = 0, overrun = 0.
REQ-031 Drive rx low for 20 clks, then high -> no valid and no frame_err; a proper 0x3C sent afterwards is received correctly.
REQ-032 Send 0x81 with the stop bit driven 0 for 3 bit periods -> one frame_err pulse, valid stays 0, no start is detected until rx returns high.
REQ-033 With ready = 0, send 0x11 then 0x22 -> data = 0x11, valid = 1, overrun = 1; assert ready for 1 clk -> valid = 0, overrun = 0 next cycle.
REQ-034 Assert reset during data bit 4 of 0xF0, release, then send 0x0F -> only 0x0F is delivered.
REQ-035 With baud offset +2% and -2%, send 0x00, 0xFF and 0x5A back-to-back with ready = 1 -> all three received intact.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised input, mid-bit sampling,
// single-entry output register with valid/ready handshake and sticky overrun.
module uart_rx #(
    parameter int CLK_FREQ = 16_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_sync1;
    logic          r_rx_s;
    logic          w_take;
    logic          w_tick;

    assign w_take = valid && ready;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (w_take) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= C_HALF_M1;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_rx_s) begin
                        r_state <= S_DATA;
                        r_cnt   <= C_DIV_M1;
                        r_bit   <= '0;
                    end else begin
                        // start bit vanished before mid-point: treat as a glitch
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= C_DIV_M1;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7)
                            r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_rx_s) begin
                        r_state <= S_IDLE;
                        // a handshake in this same cycle frees the output register
                        if (!valid || ready) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        r_state   <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a negedge
// monitor pops them on each handshake and flags any unexpected output.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int  CLK_FREQ = 16_000_000;
    localparam int  BAUD     = 115_200;
    localparam int  DIV      = CLK_FREQ / BAUD;
    localparam int  HALF     = DIV / 2;
    localparam real CLK_NS   = 1.0e9 / CLK_FREQ;
    localparam real BIT_NS   = 1.0e9 / BAUD;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         fe_seen  = 0;
    int         cyc      = 0;
    int         rise_cyc = -1;
    int         fall_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_fe    = 1'b0;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #(CLK_NS / 2.0) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (valid && !prev_valid)
            rise_cyc = cyc;
        if (valid && ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_byte got=%02h expected=none", data);
            end else begin
                exp_b = exp_q.pop_front();
                if (data !== exp_b) begin
                    bad++;
                    $display("FAIL rx_byte got=%02h expected=%02h", data, exp_b);
                end
            end
        end
        if (frame_err) begin
            fe_seen++;
            total++;
            if (prev_fe) begin
                bad++;
                $display("FAIL frame_err_width got=multi-cycle expected=1 cycle");
            end
        end
        prev_valid = valid;
        prev_fe    = frame_err;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; the stop level/length can be overridden to force a framing error.
    task automatic send(input logic [7:0] b, input real bit_ns, input logic stop_lvl, input int stop_bits);
        fall_cyc = cyc;
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_lvl;
        #(bit_ns * stop_bits);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d pending expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #(CLK_NS * 90000);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        real        bn;

        // reset state
        clks(5);
        @(negedge clk);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_overrun", 32'(overrun), 0);
        @(posedge clk); #1 reset = 1'b0;
        clks(20);

        // two bytes, ready held high; first one also checks latency
        exp_q.push_back(8'h55);
        send(8'h55, BIT_NS, 1'b1, 1);
        chk("latency_clks", 32'(rise_cyc - fall_cyc), 32'(3 + HALF + 9 * DIV));
        exp_q.push_back(8'hA3);
        send(8'hA3, BIT_NS, 1'b1, 1);
        drain("basic");
        chk("basic_overrun", 32'(overrun), 0);
        chk("basic_fe", 32'(fe_seen), 0);

        // short low glitch must not start a frame
        clks(1);
        rx = 1'b0;
        clks(20);
        rx = 1'b1;
        clks(200);
        chk("glitch_fe", 32'(fe_seen), 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, BIT_NS, 1'b1, 1);
        drain("after_glitch");

        // stop bit held low for 3 bit periods: one frame error, no byte, no restart
        clks(50);
        send(8'h81, BIT_NS, 1'b0, 3);
        clks(1500);
        chk("break_fe_count", 32'(fe_seen), 1);
        chk("break_valid", 32'(valid), 0);
        exp_q.push_back(8'h42);
        send(8'h42, BIT_NS, 1'b1, 1);
        drain("after_break");

        // overrun: hold ready low across two bytes
        clks(50);
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, BIT_NS, 1'b1, 1);
        clks(50);
        send(8'h22, BIT_NS, 1'b1, 1);
        clks(50);
        @(negedge clk);
        chk("ovr_data", 32'(data), 32'h11);
        chk("ovr_valid", 32'(valid), 1);
        chk("ovr_flag", 32'(overrun), 1);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        chk("ovr_valid_clr", 32'(valid), 0);
        chk("ovr_flag_clr", 32'(overrun), 0);
        drain("overrun");
        ready = 1'b1;

        // reset during data bit 4 of 0xF0 aborts it
        clks(50);
        fork
            send(8'hF0, BIT_NS, 1'b1, 1);
            begin
                #(BIT_NS * 5.5);
                @(posedge clk); #1 reset = 1'b1;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("midrst_valid", 32'(valid), 0);
                chk("midrst_data", 32'(data), 32'h00);
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        clks(200);
        exp_q.push_back(8'h0F);
        send(8'h0F, BIT_NS, 1'b1, 1);
        drain("after_reset");
        chk("midrst_fe", 32'(fe_seen), 1);

        // +/-2% baud offset, back-to-back frames
        for (int s = 0; s < 2; s++) begin
            bn = (s == 0) ? BIT_NS / 1.02 : BIT_NS / 0.98;
            clks(50);
            exp_q.push_back(8'h00); send(8'h00, bn, 1'b1, 1);
            exp_q.push_back(8'hFF); send(8'hFF, bn, 1'b1, 1);
            exp_q.push_back(8'h5A); send(8'h5A, bn, 1'b1, 1);
            drain(s == 0 ? "baud_plus2" : "baud_minus2");
        end

        // random bytes, random small baud skew and idle gaps
        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom_range(0, 255));
            bn = BIT_NS * (1.0 + (real'($urandom_range(0, 30)) - 15.0) / 1000.0);
            clks($urandom_range(1, 300));
            exp_q.push_back(b);
            send(b, bn, 1'b1, 1);
        end
        drain("random");

        clks(20);
        chk("final_fe", 32'(fe_seen), 1);
        chk("final_overrun", 32'(overrun), 0);
        chk("final_valid", 32'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
